uart_frame_parser: RTL
======================

# uart_frame_parser

Framed-command receiver sitting directly downstream of the UART receive FIFO and upstream of its transmit FIFO. Pops bytes from the RX FIFO and hunts for a start-of-frame byte. Collects a length-prefixed payload into an internal buffer and verifies an XOR checksum. Answers each frame through the TX FIFO with a two-byte ACK/NAK response, and exposes the accepted payload to the host logic through a random-access read port.

## Interface
- DATA_W, 8, byte width; equals the UART data width without the parity bit.
- MAX_LEN, 16, maximum payload bytes per frame; buffer depth.
- SOF, 8'hA5, start-of-frame byte.
- ACK, 8'h06, response code for a good frame.
- NAK, 8'h15, response code for a bad checksum or illegal length.
- TIMEOUT, 1000, inter-byte timeout in clk cycles; used only with the macro.
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- rx_empty  in  1  RX FIFO empty.
- r_data  in  DATA_W  RX FIFO head byte, valid whenever rx_empty=0.
- rd_uart  out  1  RX FIFO pop, one byte per asserted cycle.
- tx_full  in  1  TX FIFO full.
- w_data  out  DATA_W  byte to TX FIFO.
- wr_uart  out  1  TX FIFO push.
- frame_valid  out  1  one-cycle pulse when a frame has passed the checksum.
- frame_err  out  1  one-cycle pulse on a bad checksum, illegal length or timeout.
- frame_len  out  $clog2(MAX_LEN+1)  length of the last accepted frame.
- pl_addr  in  $clog2(MAX_LEN)  payload read index.
- pl_data  out  DATA_W  buffer[pl_addr], combinational read.
- busy  out  1  high in every state except HUNT.

## Operation
- States: HUNT, LEN, PAYLOAD, CHK, RSP_CODE, RSP_LEN.
- Consuming states are HUNT, LEN, PAYLOAD and CHK.
- In a consuming state, rd_uart = ~rx_empty. The byte on r_data is captured on the same rising edge as the pop.
- HUNT:
  - A byte equal to SOF moves to LEN.
  - Any other byte is popped and discarded, with no pulse.
- LEN:
  - Latch len and set chk = len.
  - len = 0 or len > MAX_LEN: pulse frame_err, set code = NAK, go to RSP_CODE.
  - Otherwise clear idx and go to PAYLOAD.
- PAYLOAD:
  - Write buffer[idx] = byte, update chk ^= byte, increment idx.
  - After byte len-1 is written, go to CHK.
- CHK:
  - byte == chk: pulse frame_valid, load frame_len = len, set code = ACK.
  - Otherwise: pulse frame_err, set code = NAK.
  - Go to RSP_CODE in either case.
- RSP_CODE: w_data = code; wr_uart = ~tx_full. Advance to RSP_LEN when the push occurs.
- RSP_LEN: w_data = received len byte (raw, even if illegal); wr_uart = ~tx_full. Return to HUNT when the push occurs.
- While tx_full is high in a response state:
  - wr_uart stays 0 and the state holds.
  - w_data stays stable.
  - No RX byte is consumed.
- The buffer is overwritten in place by the next frame. pl_data is only meaningful between frame_valid and the next accepted SOF.
- frame_len holds its value until the next frame_valid.
- A bad frame leaves frame_len unchanged.

## Timing
- Reset values:
  - State = HUNT.
  - rd_uart, wr_uart, frame_valid, frame_err and busy = 0.
  - frame_len = 0, w_data = 0.
  - Buffer contents are undefined.
- rd_uart is forced to 0 while Reset is low.
- Throughput is one RX byte per cycle when the FIFO is non-empty.
- Latency for a full 6-byte frame with RX and TX FIFOs ready:
  - frame_valid is high in the cycle after the CHK byte is popped.
  - The ACK push occurs in that same cycle; the len push follows one cycle later.
- Reset asserted mid-frame: the partial frame is dropped, no response is sent, and the parser restarts in HUNT.

## Configuration
- Macro UART_FRAME_TIMEOUT_EN.
- Defined:
  - A counter clears on every pop and counts while the state is LEN, PAYLOAD or CHK with rx_empty=1.
  - When the count reaches TIMEOUT-1: pulse frame_err, send no response, go to HUNT.
- Undefined:
  - The counter logic is absent and TIMEOUT is ignored.
  - The parser waits indefinitely for the next byte.

## Structure
- Package uart_frame_pkg holds:
  - The state enum.
  - Default SOF, ACK and NAK constants.
  - The function that computes the length-field width.
- One sub-module, uart_frame_buf: MAX_LEN x DATA_W register file with a synchronous write port and a combinational read port.
- The FSM, checksum and timeout counter live in the top module.

## Test plan
- Good frame: RX bytes A5 03 11 22 33 03.
  - Expect one frame_valid pulse and frame_len=3.
  - Expect pl_data = 11, 22, 33 for pl_addr = 0..2.
  - Expect TX bytes 06 03.
- Bad checksum: RX bytes A5 03 11 22 33 00.
  - Expect one frame_err pulse, no frame_valid, and TX bytes 15 03.
  - Expect frame_len to keep its prior value.
- Leading garbage and illegal length: RX bytes 00 FF A5 20.
  - Expect 00 and FF discarded silently, then a frame_err pulse.
  - Expect TX bytes 15 20, with the next byte parsed in HUNT.
- Back-pressure: hold tx_full=1 for 10 cycles after a good frame.
  - Expect wr_uart=0 throughout and no RX pops.
  - After release, expect TX 06 03 in order on consecutive cycles.
- Reset mid-frame: pull Reset low after A5 02 11, then release and send a full good frame.
  - Expect no response for the partial frame.
  - Expect normal handling of the second frame.
- Timeout (macro defined, TIMEOUT=1000): send A5 02 11, then idle for 1000 cycles.
  - Expect a frame_err pulse and no TX bytes.
  - Expect a subsequent A5 01 7E 7F to produce a frame_valid pulse.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the framed-command receiver.
// State encoding, default framing bytes and the length-field width helper.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT     = 3'd0,
        LEN      = 3'd1,
        PAYLOAD  = 3'd2,
        CHK      = 3'd3,
        RSP_CODE = 3'd4,
        RSP_LEN  = 3'd5
    } frame_state_e;

    localparam logic [7:0] SOF_DEF = 8'hA5;
    localparam logic [7:0] ACK_DEF = 8'h06;
    localparam logic [7:0] NAK_DEF = 8'h15;

    // Width needed to hold a payload length from 0 up to max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x DATA_W register file, synchronous write and
// combinational read. Contents are not reset; only the bytes of the last
// frame are ever meaningful.
module uart_frame_buf #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Store one payload byte per write strobe.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Framed-command receiver between the UART RX and TX FIFOs.
// Hunts for SOF, collects a length-prefixed payload, checks an XOR checksum
// seeded with the length byte, and answers with a {code, len} response.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                MAX_LEN = 16,
    parameter logic [DATA_W-1:0] SOF     = DATA_W'(SOF_DEF),
    parameter logic [DATA_W-1:0] ACK     = DATA_W'(ACK_DEF),
    parameter logic [DATA_W-1:0] NAK     = DATA_W'(NAK_DEF),
    parameter int                TIMEOUT = 1000,
    localparam int               LEN_W   = len_width(MAX_LEN),
    localparam int               AW      = $clog2(MAX_LEN)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_empty,
    input  logic [DATA_W-1:0] i_r_data,
    output logic              o_rd_uart,
    input  logic              i_tx_full,
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_wr_uart,
    output logic              o_frame_valid,
    output logic              o_frame_err,
    output logic [LEN_W-1:0]  o_frame_len,
    input  logic [AW-1:0]     i_pl_addr,
    output logic [DATA_W-1:0] o_pl_data,
    output logic              o_busy
);

    localparam logic [DATA_W-1:0] MAX_LEN_B = DATA_W'(MAX_LEN);
    localparam logic [DATA_W-1:0] ONE_B     = DATA_W'(1'b1);
    localparam logic [DATA_W-1:0] ZERO_B    = {DATA_W{1'b0}};

    frame_state_e      r_state;
    logic [DATA_W-1:0] r_len;
    logic [DATA_W-1:0] r_chk;
    logic [DATA_W-1:0] r_idx;
    logic [DATA_W-1:0] r_w_data;
    logic              r_frame_valid;
    logic              r_frame_err;
    logic [LEN_W-1:0]  r_frame_len;

    logic w_consume;
    logic w_pop;
    logic w_push;
    logic w_len_bad;
    logic w_buf_we;
    logic w_tmo_hit;

    // The RX head byte is taken on the same edge that pops it, so the pop is
    // a direct decode of state and FIFO status; held low during reset.
    assign w_consume = (r_state == HUNT) || (r_state == LEN) ||
                       (r_state == PAYLOAD) || (r_state == CHK);
    assign w_pop     = w_consume && !i_rx_empty && i_rst_n;
    assign w_push    = ((r_state == RSP_CODE) || (r_state == RSP_LEN)) && !i_tx_full;
    assign w_len_bad = (i_r_data == ZERO_B) || (i_r_data > MAX_LEN_B);
    assign w_buf_we  = w_pop && (r_state == PAYLOAD);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_waiting;

    assign w_waiting = ((r_state == LEN) || (r_state == PAYLOAD) ||
                        (r_state == CHK)) && i_rx_empty;
    assign w_tmo_hit = w_waiting && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Idle-cycle counter inside a frame; any pop or state change clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if (w_waiting && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1'b1);
        end else begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end
    end
`else
    logic w_unused_timeout;
    assign w_tmo_hit        = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // Frame FSM: byte capture, checksum, response sequencing and status pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= HUNT;
            r_len         <= ZERO_B;
            r_chk         <= ZERO_B;
            r_idx         <= ZERO_B;
            r_w_data      <= ZERO_B;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_len   <= {LEN_W{1'b0}};
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_pop && (i_r_data == SOF)) begin
                        r_state <= LEN;
                    end
                end
                LEN: begin
                    if (w_pop) begin
                        r_len <= i_r_data;
                        r_chk <= i_r_data;
                        if (w_len_bad) begin
                            r_frame_err <= 1'b1;
                            r_w_data    <= NAK;
                            r_state     <= RSP_CODE;
                        end else begin
                            r_idx   <= ZERO_B;
                            r_state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_pop) begin
                        r_chk <= r_chk ^ i_r_data;
                        r_idx <= r_idx + ONE_B;
                        if (r_idx == (r_len - ONE_B)) begin
                            r_state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (w_pop) begin
                        if (i_r_data == r_chk) begin
                            r_frame_valid <= 1'b1;
                            r_frame_len   <= r_len[LEN_W-1:0];
                            r_w_data      <= ACK;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_w_data    <= NAK;
                        end
                        r_state <= RSP_CODE;
                    end
                end
                RSP_CODE: begin
                    if (!i_tx_full) begin
                        r_w_data <= r_len;
                        r_state  <= RSP_LEN;
                    end
                end
                RSP_LEN: begin
                    if (!i_tx_full) begin
                        r_state <= HUNT;
                    end
                end
                default: begin
                    r_state <= HUNT;
                end
            endcase
            if (w_tmo_hit) begin
                r_frame_err <= 1'b1;
                r_state     <= HUNT;
            end
        end
    end

    uart_frame_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LEN)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    (w_buf_we),
        .i_waddr (r_idx[AW-1:0]),
        .i_wdata (i_r_data),
        .i_raddr (i_pl_addr),
        .o_rdata (o_pl_data)
    );

    assign o_rd_uart     = w_pop;
    assign o_wr_uart     = w_push;
    assign o_w_data      = r_w_data;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;
    assign o_frame_len   = r_frame_len;
    assign o_busy        = (r_state != HUNT);

endmodule
